// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Bus command encodings and I/O register addresses shared by
//               the CPU, the top level and the MMIO responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] ADDR_LED    = 9'h100;
    localparam logic [8:0] ADDR_SW     = 9'h140;
    localparam logic [8:0] ADDR_STATUS = 9'h141;
    localparam logic [8:0] ADDR_TIMER  = 9'h142;

endpackage
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Free-running prescaler driving a loadable 16-bit tick counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer #(
    parameter int PRESCALE = 50000,
    parameter int TMR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic [TMR_W-1:0] count
);

    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [c_PW-1:0]  r_pre;
    logic [TMR_W-1:0] r_count;
    logic             w_tick;

    assign w_tick = (r_pre == c_PW'(PRESCALE - 1));

    // Loads never disturb the prescaler phase; a load beats a same-cycle tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre   <= '0;
            r_count <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (load)
                r_count <= load_val;
            else if (w_tick)
                r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : mmio_responder
// Description : I/O window responder: LED register, synchronized switches,
//               sticky switch-change flag and prescaled timer.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int SW_W     = 8,
    parameter int LED_W    = 8,
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [SW_W-1:0]   SW,
    output logic [DATA_W-1:0] read_data,
    output logic              io_hit,
    output logic [LED_W-1:0]  LEDR
);

    localparam int c_TMR_W = 16;

    logic [LED_W-1:0]   r_led;
    logic [SW_W-1:0]    r_sw_s1;
    logic [SW_W-1:0]    r_sw_s2;
    logic [SW_W-1:0]    r_sw_prev;
    logic               r_sw_changed;
    logic [c_TMR_W-1:0] w_count;
    logic               w_sel_led;
    logic               w_sel_sw;
    logic               w_sel_status;
    logic               w_sel_timer;
    logic               w_wr;
    logic [DATA_W-1:0]  w_rd;
    logic               w_hit;

    assign w_sel_led    = (mem_addr == ADDR_W'(ADDR_LED));
    assign w_sel_sw     = (mem_addr == ADDR_W'(ADDR_SW));
    assign w_sel_status = (mem_addr == ADDR_W'(ADDR_STATUS));
    assign w_sel_timer  = (mem_addr == ADDR_W'(ADDR_TIMER));
    assign w_wr         = (mem_cmd == MWRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led        <= '0;
            r_sw_s1      <= '0;
            r_sw_s2      <= '0;
            r_sw_prev    <= '0;
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_s1   <= SW;
            r_sw_s2   <= r_sw_s1;
            r_sw_prev <= r_sw_s2;
            if (w_wr && w_sel_led)
                r_led <= write_data[LED_W-1:0];
            // A fresh switch change outranks a simultaneous write-1-to-clear.
            if (r_sw_s2 != r_sw_prev)
                r_sw_changed <= 1'b1;
            else if (w_wr && w_sel_status && write_data[0])
                r_sw_changed <= 1'b0;
        end
    end

    mmio_timer #(
        .PRESCALE (PRESCALE),
        .TMR_W    (c_TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_wr && w_sel_timer),
        .load_val (write_data[c_TMR_W-1:0]),
        .count    (w_count)
    );

    always_comb begin
        w_rd  = '0;
        w_hit = 1'b0;
        if (mem_cmd == MREAD) begin
            if (w_sel_led) begin
                w_hit = 1'b1;
                w_rd  = DATA_W'(r_led);
            end else if (w_sel_sw) begin
                w_hit = 1'b1;
                w_rd  = DATA_W'(r_sw_s2);
            end else if (w_sel_status) begin
                w_hit = 1'b1;
                w_rd  = DATA_W'(r_sw_changed);
            end else if (w_sel_timer) begin
                w_hit = 1'b1;
                w_rd  = DATA_W'(w_count);
            end
        end
    end

    assign read_data = w_rd;
    assign io_hit    = w_hit;
    assign LEDR      = r_led;

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_responder
// Description : Directed self-checking bench for mmio_responder (PRESCALE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_responder;
    import mmio_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  SW;
    logic [15:0] read_data;
    logic        io_hit;
    logic [7:0]  LEDR;

    int checks = 0;
    int errors = 0;

    mmio_responder #(
        .DATA_W   (16),
        .ADDR_W   (9),
        .SW_W     (8),
        .LED_W    (8),
        .PRESCALE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .SW         (SW),
        .read_data  (read_data),
        .io_hit     (io_hit),
        .LEDR       (LEDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [8:0] a, input logic [15:0] exp, input logic exp_hit,
                      input string tag);
        mem_cmd  = MREAD;
        mem_addr = a;
        #1;
        chk({tag, "_hit"}, {15'd0, io_hit}, {15'd0, exp_hit});
        chk(tag, read_data, exp);
        mem_cmd = MNONE;
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = MWRITE;
        mem_addr   = a;
        write_data = d;
        @(posedge clk);
        #1;
        mem_cmd = MNONE;
    endtask

    initial begin
        reset = 1'b1; mem_cmd = MNONE; mem_addr = '0; write_data = '0; SW = '0;

        // Reset and LED access
        step(1);
        rd(ADDR_LED, 16'h0000, 1'b1, "rst_led_rd");
        chk("rst_ledr", {8'd0, LEDR}, 16'h0000);
        step(1);
        reset = 1'b0;
        rd(ADDR_STATUS, 16'h0000, 1'b1, "rst_status");
        wr(ADDR_LED, 16'hABCD);
        chk("led_wr", {8'd0, LEDR}, 16'h00CD);
        rd(ADDR_LED, 16'h00CD, 1'b1, "led_rd");

        // Switch synchronizer and sticky flag
        SW = 8'h5A;
        step(1);
        rd(ADDR_SW, 16'h0000, 1'b1, "sw_n1");
        step(1);
        rd(ADDR_SW, 16'h005A, 1'b1, "sw_n2");
        rd(ADDR_STATUS, 16'h0000, 1'b1, "status_n2");
        step(1);
        rd(ADDR_STATUS, 16'h0001, 1'b1, "status_n3");
        wr(ADDR_STATUS, 16'h0001);
        rd(ADDR_STATUS, 16'h0000, 1'b1, "status_w1c");

        // Set lands on the same edge as the clear
        SW = 8'hA5;
        step(2);
        wr(ADDR_STATUS, 16'h0001);
        rd(ADDR_STATUS, 16'h0001, 1'b1, "status_collide");
        wr(ADDR_STATUS, 16'h0001);
        rd(ADDR_STATUS, 16'h0000, 1'b1, "status_clr2");

        // Timer
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rd(ADDR_TIMER, 16'h0000, 1'b1, "tmr_0");
        step(4);
        rd(ADDR_TIMER, 16'h0001, 1'b1, "tmr_4");
        step(16);
        rd(ADDR_TIMER, 16'h0005, 1'b1, "tmr_20");
        wr(ADDR_TIMER, 16'hFFFF);
        rd(ADDR_TIMER, 16'hFFFF, 1'b1, "tmr_ld");
        step(2);
        rd(ADDR_TIMER, 16'hFFFF, 1'b1, "tmr_pre_wrap");
        step(1);
        rd(ADDR_TIMER, 16'h0000, 1'b1, "tmr_wrap");
        step(3);
        wr(ADDR_TIMER, 16'h1234);
        rd(ADDR_TIMER, 16'h1234, 1'b1, "tmr_ld_tick");
        step(4);
        rd(ADDR_TIMER, 16'h1235, 1'b1, "tmr_after_ld");

        // Decode misses
        wr(ADDR_LED, 16'h0077);
        rd(9'h0FF, 16'h0000, 1'b0, "miss_0ff");
        rd(9'h143, 16'h0000, 1'b0, "miss_143");
        mem_cmd  = 2'b11;
        mem_addr = ADDR_LED;
        #1;
        chk("cmd11_hit", {15'd0, io_hit}, 16'h0000);
        chk("cmd11_data", read_data, 16'h0000);
        mem_cmd = MNONE;
        wr(ADDR_SW, 16'h00FF);
        rd(ADDR_SW, 16'h00A5, 1'b1, "sw_ro");
        chk("ledr_after_sw_wr", {8'd0, LEDR}, 16'h0077);

        // Reset mid-operation
        SW = 8'hC3;
        step(3);
        wr(ADDR_LED, 16'h003C);
        wr(ADDR_TIMER, 16'h0007);
        rd(ADDR_TIMER, 16'h0007, 1'b1, "pre_rst_tmr");
        rd(ADDR_STATUS, 16'h0001, 1'b1, "pre_rst_status");
        chk("pre_rst_ledr", {8'd0, LEDR}, 16'h003C);
        reset      = 1'b1;
        mem_cmd    = MWRITE;
        mem_addr   = ADDR_LED;
        write_data = 16'h00FF;
        step(1);
        reset   = 1'b0;
        mem_cmd = MNONE;
        chk("rst_ledr_mid", {8'd0, LEDR}, 16'h0000);
        rd(ADDR_TIMER, 16'h0000, 1'b1, "rst_tmr_mid");
        rd(ADDR_STATUS, 16'h0000, 1'b1, "rst_status_mid");
        rd(ADDR_SW, 16'h0000, 1'b1, "rst_sw_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
